// File: rtl/csa_final_adder.sv
// ----------------------------------------------------------------------------
// csa_final_adder
//
// Pipelined carry-propagate adder that resolves the redundant (sum, carry)
// pair coming out of the multiplier's 3:2 compressor tree into a binary
// product mantissa. The W-bit addition is cut into NSTG = W/SEG segments.
// Stage k adds segment k plus the carry registered by stage k-1. Finished
// low segments ride along with the still-unprocessed high segments.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       asynchronous active-high reset
//   in_valid  sum_i/carry_i/tag_i valid
//   in_ready  stage 0 can accept
//   sum_i     sum vector from the compressor tree (W bits)
//   carry_i   carry vector, already bit-aligned with sum_i (W bits)
//   tag_i     sideband tag, returned unchanged with the result
//   out_valid result valid
//   out_ready downstream accepts
//   res_o     sum_i + carry_i, W+1 bits; bit W is the carry-out
//   tag_o     tag of the result
//   zero_o    res_o == 0, qualified by out_valid
//             (present only when CPA_ZERO_DETECT_EN is defined)
//
// Optional feature macro: CPA_ZERO_DETECT_EN
// ----------------------------------------------------------------------------
module csa_final_adder #(
    parameter int unsigned W    = 32,
    parameter int unsigned SEG  = 8,
    parameter int unsigned TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    sum_i,
    input  logic [W-1:0]    carry_i,
    input  logic [TAGW-1:0] tag_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W:0]      res_o,
    output logic [TAGW-1:0] tag_o
`ifdef CPA_ZERO_DETECT_EN
    ,
    output logic            zero_o
`endif
);

    localparam int unsigned NSTG = W / SEG;

    if ((SEG == 0) || ((W % SEG) != 0)) begin : g_bad_param
        $error("csa_final_adder: W must be a non-zero multiple of SEG");
    end

    // w_ready[k] is the ready seen by stage k; w_ready[NSTG] is the sink.
    logic [NSTG:0] w_ready;

    assign w_ready[NSTG] = out_ready;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        // Upstream view for this stage.
        logic            w_vin;
        logic [W-1:0]    w_acc_in;
        logic [W-1:0]    w_car_in;
        logic            w_cy_in;
        logic [TAGW-1:0] w_tag_in;

        // Stage registers.
        logic            r_valid;
        logic [TAGW-1:0] r_tag;
        logic [W-1:0]    r_acc;
        logic            r_cy;

        // Segment adder and next accumulator image.
        logic [SEG:0]    w_seg;
        logic [W-1:0]    w_acc_nxt;

        if (k == 0) begin : g_first
            assign w_vin    = in_valid;
            assign w_acc_in = sum_i;
            assign w_car_in = carry_i;
            assign w_cy_in  = 1'b0;
            assign w_tag_in = tag_i;
        end else begin : g_next
            assign w_vin    = g_stage[k-1].r_valid;
            assign w_acc_in = g_stage[k-1].r_acc;
            assign w_car_in = g_stage[k-1].g_car.r_car;
            assign w_cy_in  = g_stage[k-1].r_cy;
            assign w_tag_in = g_stage[k-1].r_tag;
        end

        // A bubble (or a stage whose successor is ready) may always load.
        assign w_ready[k] = !r_valid || w_ready[k+1];

        assign w_seg = {1'b0, w_acc_in[k*SEG +: SEG]}
                     + {1'b0, w_car_in[k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_cy_in};

        // Lower segments already hold results, higher ones still hold sum bits.
        always_comb begin
            w_acc_nxt                 = w_acc_in;
            w_acc_nxt[k*SEG +: SEG]   = w_seg[SEG-1:0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_tag   <= '0;
                r_acc   <= '0;
                r_cy    <= 1'b0;
            end else if (w_ready[k]) begin
                r_valid <= w_vin;
                // Payload only moves with a real operand so a bubble never
                // disturbs what an output stage is presenting.
                if (w_vin) begin
                    r_tag <= w_tag_in;
                    r_acc <= w_acc_nxt;
                    r_cy  <= w_seg[SEG];
                end
            end
        end

        // Carry vector is only needed while higher segments remain.
        if (k < NSTG - 1) begin : g_car
            logic [W-1:0] r_car;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_car <= '0;
                end else if (w_ready[k] && w_vin) begin
                    r_car <= w_car_in;
                end
            end
        end else begin : g_last
            // The final stage consumes only its own carry segment.
            logic w_unused_car;
            assign w_unused_car = ^w_car_in;
        end

`ifdef CPA_ZERO_DETECT_EN
        logic w_zero_in;
        logic w_zero_nxt;
        logic r_zero;

        if (k == 0) begin : g_zfirst
            assign w_zero_in = 1'b1;
        end else begin : g_znext
            assign w_zero_in = g_stage[k-1].r_zero;
        end

        // The last stage folds in the carry-out so the flag covers all of res_o.
        if (k == NSTG - 1) begin : g_zlast
            assign w_zero_nxt = w_zero_in && (w_seg == '0);
        end else begin : g_zmid
            assign w_zero_nxt = w_zero_in && (w_seg[SEG-1:0] == '0);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_zero <= 1'b0;
            end else if (w_ready[k] && w_vin) begin
                r_zero <= w_zero_nxt;
            end
        end
`endif
    end

    assign in_ready  = w_ready[0];
    assign out_valid = g_stage[NSTG-1].r_valid;
    assign res_o     = {g_stage[NSTG-1].r_cy, g_stage[NSTG-1].r_acc};
    assign tag_o     = g_stage[NSTG-1].r_tag;

`ifdef CPA_ZERO_DETECT_EN
    assign zero_o    = g_stage[NSTG-1].r_zero && g_stage[NSTG-1].r_valid;
`endif

endmodule

// File: tb/tb_csa_final_adder.sv
// ----------------------------------------------------------------------------
// tb_csa_final_adder
//
// Scoreboard bench for csa_final_adder. Accepted operands are turned into
// expected results (plain W+1-bit addition) and queued; an output monitor pops
// and compares whenever a result is handed downstream.
// ----------------------------------------------------------------------------
module tb_csa_final_adder;

    localparam int unsigned W    = 32;
    localparam int unsigned SEG  = 8;
    localparam int unsigned TAGW = 4;
    localparam int unsigned NSTG = W / SEG;

    typedef struct {
        logic [W:0]      res;
        logic [TAGW-1:0] tag;
        int              cyc;
        bit              chk_lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    sum_i;
    logic [W-1:0]    carry_i;
    logic [TAGW-1:0] tag_i;
    logic            out_valid;
    logic            out_ready;
    logic [W:0]      res_o;
    logic [TAGW-1:0] tag_o;
`ifdef CPA_ZERO_DETECT_EN
    logic            zero_o;
`endif

    exp_t  q[$];
    int    n_chk   = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    lat_on  = 1'b0;
    bit    bp_on   = 1'b0;
    bit    saw_inr_low = 1'b0;
    bit    prev_stall  = 1'b0;
    logic [W:0]      prev_res;
    logic [TAGW-1:0] prev_tag;
    int    n_out   = 0;

    csa_final_adder #(
        .W    (W),
        .SEG  (SEG),
        .TAGW (TAGW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_i     (sum_i),
        .carry_i   (carry_i),
        .tag_i     (tag_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_o     (res_o),
        .tag_o     (tag_o)
`ifdef CPA_ZERO_DETECT_EN
        ,
        .zero_o    (zero_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input side: every accepted operand pair produces one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            e.res     = {1'b0, sum_i} + {1'b0, carry_i};
            e.tag     = tag_i;
            e.cyc     = cyc;
            e.chk_lat = lat_on;
            q.push_back(e);
        end
        if (bp_on && !in_ready) saw_inr_low = 1'b1;
    end

    // Output side: pop and compare on every downstream transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_res", 64'(res_o), 64'(prev_res));
                check("stall_tag", 64'(tag_o), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check("unexpected_out", 64'(res_o), 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    check("res", 64'(res_o), 64'(e.res));
                    check("tag", 64'(tag_o), 64'(e.tag));
`ifdef CPA_ZERO_DETECT_EN
                    check("zero", 64'(zero_o), 64'(e.res == '0));
`endif
                    if (e.chk_lat) check("latency", 64'(cyc - e.cyc), 64'(NSTG));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = res_o;
            prev_tag   = tag_o;
        end
    end

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input logic [TAGW-1:0] t);
        int n;
        sum_i    = s;
        carry_i  = c;
        tag_i    = t;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                check("send_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum_i     = '0;
        carry_i   = '0;
        tag_i     = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_res", 64'(res_o), 64'd0);
        check("rst_tag", 64'(tag_o), 64'd0);
`ifdef CPA_ZERO_DETECT_EN
        check("rst_zero", 64'(zero_o), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Full carry ripple through every segment.
        lat_on = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 4'hA);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("ripple_latency", 64'(n), 64'(NSTG));
        check("ripple_res", 64'(res_o), 64'h1_0000_0000);
        check("ripple_tag", 64'(tag_o), 64'hA);
`ifdef CPA_ZERO_DETECT_EN
        check("ripple_zero", 64'(zero_o), 64'd0);
`endif
        drain();

        // Zero-detect operands (result also checked without the feature).
        send(32'h8000_0000, 32'h8000_0000, 4'h3);
        send(32'h0000_0000, 32'h0000_0000, 4'h4);
        drain();

        // Streaming: back-to-back outputs once the pipe fills.
        n_out = 0;
        for (int i = 0; i < 16; i++) send($urandom, $urandom, 4'($urandom));
        drain();
        check("stream_count", 64'(n_out), 64'd16);
        lat_on = 1'b0;

        // Back-pressure: out_ready low for five cycles mid-stream.
        bp_on = 1'b1;
        saw_inr_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send($urandom, $urandom, 4'(i));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        bp_on = 1'b0;
        check("bp_in_ready_fell", 64'(saw_inr_low), 64'd1);

        // Bubbles compact toward the output while stalled.
        out_ready = 1'b0;
        send($urandom, $urandom, 4'h1);
        idle(1);
        send($urandom, $urandom, 4'h2);
        idle(1);
        send($urandom, $urandom, 4'h3);
        idle(1);
        @(negedge clk);
        check("bubble_out_valid", 64'(out_valid), 64'd1);
        check("bubble_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("bubble_compact", 64'(n), 64'd3);
        drain();

        // Random traffic with random back-pressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send($urandom, $urandom, 4'($urandom));
                    idle(int'($urandom_range(0, 2)));
                end
            end
            begin
                repeat (160) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three operands in flight: nothing may emerge.
        send($urandom, $urandom, 4'h7);
        send($urandom, $urandom, 4'h8);
        send($urandom, $urandom, 4'h9);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_res", 64'(res_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || res_o != '0) n++;
        end
        check("midrst_quiet", 64'(n), 64'd0);

        // Pipe still works after the flush.
        @(posedge clk);
        #1;
        send(32'h1234_5678, 32'h1111_1111, 4'h5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
